sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 14 +
 rtl/sram_wait_cnt.sv | 27 ++
 rtl/sram_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int          CNT_W         = 4;
   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

endpackage

// File: rtl/sram_wait_cnt.sv
// Wait-state down-counter for one 16-bit half access.
module sram_wait_cnt
   import sram_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] init,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= init;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// CPU memory-stage to 16-bit SRAM bridge: each 32-bit access is two halves.
// Optional address range checking is enabled by SRAM_CTRL_RANGE_CHECK_EN.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
`ifdef SRAM_CTRL_RANGE_CHECK_EN
   output logic               range_err,
`endif
   output logic               sram_we_n
);

   localparam int IDX_W = SRAM_AW - 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

   state_t            state;
   state_t            next;
   logic              req;
   logic              zero;
   logic              load;
   logic              dec;
   logic [31:0]       addr_q;
   logic [31:0]       data_q;
   logic              wr_q;
   logic [31:0]       diff;
   logic [IDX_W-1:0]  idx;
   logic              oor;

   assign req  = rd_en | wr_en;
   // Upper index bits drop out here, so unchecked addresses wrap.
   assign diff = addr_q - BASE_ADDR;
   assign idx  = IDX_W'(diff >> 2);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
   logic [31:0] in_diff;
   logic        err_q;

   assign in_diff = address - BASE_ADDR;
   assign oor = (address < BASE_ADDR)
              || ((in_diff >> (SRAM_AW + 1)) != 32'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state == IDLE && req) begin
         err_q <= oor;
      end
   end

   assign range_err = !rst && state == DONE && err_q;
`else
   assign oor = 1'b0;
`endif

   assign load = (state == IDLE && req) || (state == LO && zero);
   assign dec  = (state == LO || state == HI) && !zero;

   sram_wait_cnt u_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .dec  (dec),
      .init (CNT_INIT),
      .zero (zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE: if (req) next = oor ? DONE : LO;
         LO:   if (zero) next = HI;
         HI:   if (zero) next = DONE;
         DONE: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
         wr_q   <= 1'b0;
      end else if (state == IDLE && req) begin
         addr_q <= address;
         data_q <= write_data;
         wr_q   <= wr_en;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         read_data <= '0;
      end else if (!wr_q && zero) begin
         if (state == LO) read_data[15:0]  <= sram_dq_in;
         if (state == HI) read_data[31:16] <= sram_dq_in;
      end
   end

   always_comb begin
      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      if (rst) begin
         ready = 1'b1;
      end else begin
         unique case (state)
            IDLE: ready = !req;
            LO: begin
               sram_addr = {idx, 1'b0};
               if (wr_q) begin
                  sram_dq_oe  = 1'b1;
                  sram_we_n   = 1'b0;
                  sram_dq_out = data_q[15:0];
               end
            end
            HI: begin
               sram_addr = {idx, 1'b1};
               if (wr_q) begin
                  sram_dq_oe  = 1'b1;
                  sram_we_n   = 1'b0;
                  sram_dq_out = data_q[31:16];
               end
            end
            DONE: ready = 1'b1;
         endcase
      end
   end

endmodule
